// File: rtl/mem_bus_if.sv
// Data-memory bus: one req/ack transaction per access, little-endian byte lanes.
// Latency: none, wires only.
// Backpressure: the master holds bus_req and every request field stable until bus_ack.
interface mem_bus_if #(
    parameter int ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store responder: one decoded access -> one bus transaction.
// Latency: ack in the Nth request cycle gives N+1 stall cycles, result in the following RESP cycle.
// Backpressure: stall holds the pipeline while a transaction is pending; a silent bus times out after TIMEOUT cycles.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRd,
    input  logic              memWt,
    input  logic [2:0]        Load,
    input  logic [1:0]        Store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic              stall,
    output logic [31:0]       ld_data,
    output logic              ld_valid,
    output logic              align_err,
    output logic              bus_err,
    mem_bus_if.master         bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t            state_q, state_d;
    size_t             size_q, size_d;
    logic              op_ld_q, op_ld_d;
    logic              uns_q, uns_d;
    logic              err_q, err_d;
    logic [1:0]        lane_q, lane_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic              req_c;

    // Decode of the incoming access (only meaningful in IDLE).
    logic  acc_c, is_ld_c, mis_c, uns_c;
    size_t size_c;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    // Lane-selected pieces of the returning read word.
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;

    // Decode size, alignment, byte enables and replicated write data.
    always_comb begin
        acc_c   = memRd | memWt;
        is_ld_c = memRd;
        uns_c   = Load[0];
        if (is_ld_c) begin
            size_c = Load[2] ? SZ_W : (Load[1] ? SZ_H : SZ_B);
        end else begin
            size_c = Store[1] ? SZ_W : (Store[0] ? SZ_H : SZ_B);
        end
        mis_c = ((size_c == SZ_H) && addr[0]) || ((size_c == SZ_W) && (addr[1:0] != 2'b00));
        be_c    = 4'b1111;
        wdata_c = st_data;
        if (!is_ld_c) begin
            case (size_c)
                SZ_B: begin
                    be_c    = 4'b0001 << addr[1:0];
                    wdata_c = {4{st_data[7:0]}};
                end
                SZ_H: begin
                    be_c    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_c = {2{st_data[15:0]}};
                end
                default: begin
                    be_c    = 4'b1111;
                    wdata_c = st_data;
                end
            endcase
        end
    end

    // Extract and extend the addressed byte/half/word from the read data.
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = bus.bus_rdata[7:0];
            2'd1:    rd_byte = bus.bus_rdata[15:8];
            2'd2:    rd_byte = bus.bus_rdata[23:16];
            default: rd_byte = bus.bus_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (size_q)
            SZ_B:    rd_ext = uns_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            SZ_H:    rd_ext = uns_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = bus.bus_rdata;
        endcase
    end

    // Next-state logic and strobes; reset forces every combinational output low.
    always_comb begin
        state_d   = state_q;
        size_d    = size_q;
        op_ld_d   = op_ld_q;
        uns_d     = uns_q;
        err_d     = err_q;
        lane_d    = lane_q;
        cnt_d     = cnt_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        baddr_d   = baddr_q;
        ld_data_d = ld_data_q;
        stall     = 1'b0;
        ld_valid  = 1'b0;
        align_err = 1'b0;
        bus_err   = 1'b0;
        ld_data   = 32'b0;
        req_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_c) begin
                    if (mis_c) begin
                        align_err = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        op_ld_d = is_ld_c;
                        size_d  = size_c;
                        uns_d   = uns_c;
                        lane_d  = addr[1:0];
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        baddr_d = {addr[ADDR_W-1:2], 2'b00};
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                req_c = 1'b1;
                if (bus.bus_ack) begin
                    err_d     = 1'b0;
                    ld_data_d = op_ld_q ? rd_ext : 32'b0;
                    state_d   = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d     = 1'b1;
                    ld_data_d = 32'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                ld_valid = op_ld_q && !err_q;
                bus_err  = err_q;
                ld_data  = (op_ld_q && !err_q) ? ld_data_q : 32'b0;
                state_d  = IDLE;
            end
        endcase
        if (rst) begin
            stall     = 1'b0;
            ld_valid  = 1'b0;
            align_err = 1'b0;
            bus_err   = 1'b0;
            ld_data   = 32'b0;
            req_c     = 1'b0;
        end
    end

    // State and latched transaction fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            size_q    <= SZ_B;
            op_ld_q   <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            lane_q    <= 2'b0;
            cnt_q     <= '0;
            be_q      <= 4'b0;
            wdata_q   <= 32'b0;
            baddr_q   <= '0;
            ld_data_q <= 32'b0;
        end else begin
            state_q   <= state_d;
            size_q    <= size_d;
            op_ld_q   <= op_ld_d;
            uns_q     <= uns_d;
            err_q     <= err_d;
            lane_q    <= lane_d;
            cnt_q     <= cnt_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            baddr_q   <= baddr_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign bus.bus_req   = req_c;
    assign bus.bus_we    = !op_ld_q && (be_q != 4'b0);
    assign bus.bus_addr  = baddr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a hand-driven memory ack.
// Latency: checks stall/req cycle counts and result timing per access.
// Backpressure: acks are withheld or delayed to exercise stall and timeout.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        memRd, memWt;
    logic [2:0]  Load;
    logic [1:0]  Store;
    logic [31:0] addr, st_data;
    logic        stall, ld_valid, align_err, bus_err;
    logic [31:0] ld_data;
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;

    mem_bus_if #(.ADDR_W(32)) bus ();

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .memRd(memRd), .memWt(memWt), .Load(Load), .Store(Store),
        .addr(addr), .st_data(st_data), .stall(stall), .ld_data(ld_data),
        .ld_valid(ld_valid), .align_err(align_err), .bus_err(bus_err), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one aligned access from IDLE; ack is raised in the ack_at-th request cycle (0 = never).
    task automatic run_acc(input logic rd, input logic wt, input logic [2:0] ld, input logic [1:0] st,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                           input int ack_at, output int n_stall, output int n_req,
                           output logic [31:0] r_ld, output logic r_ldv, output logic r_berr,
                           output logic [3:0] r_be, output logic [31:0] r_wd, output logic [31:0] r_ba,
                           output logic r_we, output int req_at, output int resp_at);
        int w;
        bit done;
        n_stall = 0; n_req = 0; w = 0; done = 0; req_at = -1; resp_at = -1;
        r_ld = 0; r_ldv = 0; r_berr = 0; r_be = 0; r_wd = 0; r_ba = 0; r_we = 0;
        memRd = rd; memWt = wt; Load = ld; Store = st; addr = a; st_data = sd;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (bus.bus_req) begin
                if (req_at < 0) begin
                    req_at = cyc;
                    r_be = bus.bus_be; r_wd = bus.bus_wdata; r_ba = bus.bus_addr; r_we = bus.bus_we;
                end
                n_req++;
                w++;
                bus.bus_rdata = rdat;
                bus.bus_ack   = (w == ack_at);
            end
            if (c > 0 && !stall) begin
                done = 1; resp_at = cyc;
                r_ld = ld_data; r_ldv = ld_valid; r_berr = bus_err;
            end
            @(posedge clk); #1;
            memRd = 0; memWt = 0; bus.bus_ack = 0;
        end
        if (!done) chk("acc_done", 32'd0, 32'd1);
    endtask

    int          ns, nr, ra, rs, rs1;
    logic [31:0] rld, rwd, rba;
    logic        rldv, rberr, rwe;
    logic [3:0]  rbe;

    initial begin
        rst = 1; memRd = 0; memWt = 0; Load = 0; Store = 0; addr = 0; st_data = 0;
        bus.bus_ack = 0; bus.bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_req", {31'b0, bus.bus_req}, 0);
        chk("rst_be", {28'b0, bus.bus_be}, 0);
        chk("rst_ld", ld_data, 0);
        @(posedge clk); #1; rst = 0;

        // lb at 0x103, ack in first request cycle
        run_acc(1, 0, 3'b000, 2'b00, 32'h103, 0, 32'h80FF_1234, 1, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("lb_addr", rba, 32'h100);
        chk("lb_be", {28'b0, rbe}, 32'hF);
        chk("lb_we", {31'b0, rwe}, 0);
        chk("lb_stall", ns, 2);
        chk("lb_data", rld, 32'hFFFF_FF80);
        chk("lb_valid", {31'b0, rldv}, 1);
        @(negedge clk);
        chk("lb_valid_1cyc", {31'b0, ld_valid}, 0);
        @(posedge clk); #1;

        // sh at 0x22 then lhu at 0x22
        run_acc(0, 1, 3'b000, 2'b01, 32'h22, 32'hDEAD_BEEF, 0, 1, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("sh_we", {31'b0, rwe}, 1);
        chk("sh_be", {28'b0, rbe}, 32'hC);
        chk("sh_wdata", rwd, 32'hBEEF_BEEF);
        chk("sh_addr", rba, 32'h20);
        chk("sh_novalid", {31'b0, rldv}, 0);
        run_acc(1, 0, 3'b011, 2'b00, 32'h22, 0, 32'hBEEF_0000, 2, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("lhu_data", rld, 32'h0000_BEEF);
        chk("lhu_stall", ns, 3);

        // lh sign extension, with memRd and memWt both high (load wins)
        run_acc(1, 1, 3'b010, 2'b10, 32'h2, 32'h5555_5555, 32'h8001_0000, 1, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("lh_data", rld, 32'hFFFF_8001);
        chk("rdwt_we", {31'b0, rwe}, 0);

        // misaligned lw at 0x41, sh at 0x43
        memRd = 1; Load = 3'b100; addr = 32'h41;
        @(negedge clk);
        chk("lw_mis_err", {31'b0, align_err}, 1);
        chk("lw_mis_stall", {31'b0, stall}, 0);
        @(posedge clk); #1; memRd = 0;
        @(negedge clk);
        chk("lw_mis_1cyc", {31'b0, align_err}, 0);
        chk("lw_mis_req", {31'b0, bus.bus_req}, 0);
        @(posedge clk); #1;
        memWt = 1; Store = 2'b01; addr = 32'h43;
        @(negedge clk);
        chk("sh_mis_err", {31'b0, align_err}, 1);
        chk("sh_mis_stall", {31'b0, stall}, 0);
        @(posedge clk); #1; memWt = 0;
        @(negedge clk);
        chk("sh_mis_req", {31'b0, bus.bus_req}, 0);
        @(posedge clk); #1;

        // sw with ack withheld -> timeout
        run_acc(0, 1, 3'b000, 2'b10, 32'h10, 32'h1234_5678, 0, 0, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("to_req_cycles", nr, 16);
        chk("to_stall", ns, 17);
        chk("to_berr", {31'b0, rberr}, 1);
        chk("to_ldv", {31'b0, rldv}, 0);
        chk("to_ld", rld, 0);
        @(negedge clk);
        chk("to_berr_1cyc", {31'b0, bus_err}, 0);
        chk("to_idle_stall", {31'b0, stall}, 0);
        @(posedge clk); #1;

        // reset in the 3rd WAIT cycle, then a stray ack
        memRd = 1; Load = 3'b100; addr = 32'h80;
        @(posedge clk); #1; memRd = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1;
        @(posedge clk); #1; rst = 0; bus.bus_ack = 1; bus.bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rstw_req", {31'b0, bus.bus_req}, 0);
        chk("rstw_stall", {31'b0, stall}, 0);
        chk("rstw_addr", bus.bus_addr, 0);
        chk("rstw_be", {28'b0, bus.bus_be}, 0);
        @(posedge clk); #1; bus.bus_ack = 0;
        @(negedge clk);
        chk("rstw_ldv", {31'b0, ld_valid}, 0);
        chk("rstw_berr", {31'b0, bus_err}, 0);
        @(posedge clk); #1;
        run_acc(0, 1, 3'b000, 2'b00, 32'h1, 32'h0000_00A5, 0, 1, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("rsb_be", {28'b0, rbe}, 32'h2);
        chk("rsb_wdata", rwd, 32'hA5A5_A5A5);
        chk("rsb_addr", rba, 32'h0);

        // back-to-back sb at 0x0 then lw at 0x4, each acked in the 3rd request cycle
        run_acc(0, 1, 3'b000, 2'b00, 32'h0, 32'h0000_0011, 0, 3, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("b2b1_be", {28'b0, rbe}, 32'h1);
        chk("b2b1_stall", ns, 4);
        rs1 = rs;
        run_acc(1, 0, 3'b100, 2'b00, 32'h4, 0, 32'hCAFE_F00D, 3, ns, nr, rld, rldv, rberr, rbe, rwd, rba, rwe, ra, rs);
        chk("b2b2_be", {28'b0, rbe}, 32'hF);
        chk("b2b2_gap", ra - rs1, 2);
        chk("b2b2_data", rld, 32'hCAFE_F00D);
        chk("b2b2_addr", rba, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder for the pipelined CPU's load/store control codes (memRd, memWt, Load[2:0], Store[1:0]).
- Turns one decoded access into a single req/ack transaction on the data-memory bus, using little-endian byte lanes.
- Stalls the pipeline until the transaction completes.
- Returns sign- or zero-extended load data, and flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, max cycles waiting for bus_ack before bus_err (must be >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- memRd  in  1  load request from the control unit.
- memWt  in  1  store request from the control unit.
- Load  in  3  000 lb, 001 lbu, 010 lh, 011 lhu, 100 lw.
- Store  in  2  00 sb, 01 sh, 10 sw.
- addr  in  ADDR_W  effective byte address (ALU result).
- st_data  in  32  rt value for stores.
- stall  out  1  holds IF/ID/EX/MEM when high.
- ld_data  out  32  extended load result, valid while ld_valid.
- ld_valid  out  1  one-cycle load-complete strobe.
- align_err  out  1  one-cycle misalignment strobe.
- bus_err  out  1  one-cycle timeout strobe.
- bus_req  out  1  bus request, held until ack.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address (addr with [1:0] forced to 00).
- bus_be  out  4  byte enables, bit i = byte lane i.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion from memory.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; every output 0 (bus_addr/bus_be/bus_wdata 0, stall 0). Reset overrides all other activity; mid-transaction it drops bus_req immediately and discards any pending ack.
- Access request: acc = memRd | memWt.
  - memRd and memWt both high is treated as a load; the store is ignored.
  - Load codes 101–111 are treated as lw.
  - Store code 11 is treated as sw.
- Misalignment:
  - lh/lhu/sh are misaligned when addr[0] = 1.
  - lw/sw are misaligned when addr[1:0] != 0.
  - Byte accesses are never misaligned.
- Byte enables and write data:
  - sb: be = 1 << addr[1:0]; wdata = {4{st_data[7:0]}}.
  - sh: be = addr[1] ? 1100 : 0011; wdata = {2{st_data[15:0]}}.
  - sw / all loads: be = 1111; wdata = st_data.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - acc and misaligned: align_err = 1 for this cycle, stall = 0, no bus activity, stay IDLE.
  - acc and aligned:
    - Stall = 1 combinationally in this cycle.
    - Latch op, Load/Store code, addr[1:0], be, wdata and bus_addr.
    - bus_req = 1 from the next cycle; go to WAIT.
  - No acc: stall = 0.
- WAIT:
  - stall = 1; bus_req and the latched bus fields are held stable.
  - Timeout counter starts at 0 on entry and increments each cycle.
  - On bus_ack:
    - Drop bus_req on the next edge.
    - For a load, capture bus_rdata and register ld_data.
    - Go to RESP.
  - If the counter reaches TIMEOUT-1 without ack: drop bus_req, set the error flag, go to RESP.
  - An ack in the same cycle as the timeout wins: normal completion.
- Load extraction from the latched rdata and addr[1:0]:
  - lb/lbu: byte addr[1:0], sign- or zero-extended.
  - lh/lhu: half addr[1], sign- or zero-extended.
  - lw: whole word.
- RESP (one cycle):
  - stall = 0, so the pipeline advances at the end of this cycle.
  - ld_valid = 1 for a successful load; bus_err = 1 if timed out (ld_data = 0 in that case).
  - Inputs are ignored, since they still belong to the same instruction.
  - Always return to IDLE.
- Latency: with an ack N cycles after bus_req rises (N >= 1), stall spans N+1 cycles and the result appears in the cycle after ack. Zero-wait memory gives 2 stall cycles plus 1 RESP cycle.
- Back-to-back accesses: a new access is accepted in the IDLE cycle immediately after RESP.
- A bus_ack in IDLE or RESP is ignored.

Test Plan:
- lb at addr 0x103, rdata 0x80FF_1234 acked 1 cycle after req -> bus_addr 0x100, be 1111, ld_data 0xFFFF_FF80, ld_valid for 1 cycle, stall high for 2 cycles.
- sh at addr 0x22, st_data 0xDEAD_BEEF -> bus_we 1, be 1100, wdata 0xBEEF_BEEF, bus_addr 0x20; lhu at 0x22 with rdata 0xBEEF_0000 -> ld_data 0x0000_BEEF.
- lw at addr 0x41 -> align_err pulses 1 cycle, bus_req never rises, stall 0; same for sh at 0x43.
- sw with bus_ack withheld -> bus_req held exactly TIMEOUT cycles (16), then bus_err 1 cycle, ld_valid 0, stall released, FSM back in IDLE.
- rst asserted on the 3rd WAIT cycle, then ack arrives -> bus_req 0 on the next edge, the ack is ignored, all outputs 0, a following sb proceeds normally.
- Back-to-back sb at 0x0 then lw at 0x4, each acked after 3 cycles -> two separate transactions, second bus_req rises 2 cycles after the first RESP, be sequence 0001 then 1111.
